// File: rtl/quad_decoder_pkg.sv
// Shared phase encodings and direction constants for the quadrature decoder.
// Phases are {A, B}; the up (A-leads) cycle is 00 -> 10 -> 11 -> 01 -> 00.
package quad_decoder_pkg;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_10 = 2'b10;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_01 = 2'b01;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    function automatic logic [1:0] next_up(input logic [1:0] phase);
        logic [1:0] nxt;
        case (phase)
            PH_00:   nxt = PH_10;
            PH_10:   nxt = PH_11;
            PH_11:   nxt = PH_01;
            default: nxt = PH_00;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/quad_glitch_filter.sv
// Two-flop synchroniser followed by a stability filter: the output follows the
// synchronised input only after it has differed for FILT_CYCLES consecutive clocks.
module quad_glitch_filter #(
    parameter int FILT_CYCLES = 3,
    parameter int FILT_W      = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
        end
    end

    generate
        if (FILT_CYCLES == 0) begin : g_bypass
            // Bypass adds no register so edge-to-pulse latency stays 2 + 0 + 1.
            assign dout = r_sync2;
        end else begin : g_filt
            localparam logic [FILT_W-1:0] LIMIT   = FILT_W'(FILT_CYCLES);
            localparam logic [FILT_W-1:0] CNT_ONE = FILT_W'(1);

            logic [FILT_W-1:0] r_cnt;
            logic [FILT_W-1:0] w_cnt_nxt;
            logic              r_filt;

            assign w_cnt_nxt = r_cnt + CNT_ONE;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_cnt  <= '0;
                    r_filt <= 1'b0;
                end else if (r_sync2 != r_filt) begin
                    if (w_cnt_nxt == LIMIT) begin
                        r_filt <= r_sync2;
                        r_cnt  <= '0;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                    end
                end else begin
                    r_cnt <= '0;
                end
            end

            assign dout = r_filt;
        end
    endgenerate

endmodule

// File: rtl/quad_decoder_298a.sv
// Quadrature encoder front-end driving an up/down counter's en/up/load/d inputs.
// Define QUAD_DECODER_X4_EN for x4 decoding; the default build decodes x1.
module quad_decoder_298a
    import quad_decoder_pkg::*;
#(
    parameter int         FILT_CYCLES = 3,
    parameter logic [7:0] INDEX_VAL   = 8'd0,
    parameter int         FILT_W      = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       qa,
    input  logic       qb,
    input  logic       qi,
    input  logic       idx_arm,
    input  logic       clr_err,
    output logic       en,
    output logic       up,
    output logic       load,
    output logic [7:0] d,
    output logic       err
);

    logic       w_fa;
    logic       w_fb;
    logic       w_fi;
    logic [1:0] w_phase;
    logic       w_step_up;
    logic       w_step_dn;
    logic       w_illegal;
    logic       w_count;

    logic [1:0] r_prev;
    logic       r_fi_prev;
    logic       r_en;
    logic       r_up;
    logic       r_load;
    logic       r_err;

    quad_glitch_filter #(.FILT_CYCLES(FILT_CYCLES), .FILT_W(FILT_W)) u_filt_a (
        .clk(clk), .reset_n(reset_n), .din(qa), .dout(w_fa)
    );
    quad_glitch_filter #(.FILT_CYCLES(FILT_CYCLES), .FILT_W(FILT_W)) u_filt_b (
        .clk(clk), .reset_n(reset_n), .din(qb), .dout(w_fb)
    );
    quad_glitch_filter #(.FILT_CYCLES(FILT_CYCLES), .FILT_W(FILT_W)) u_filt_i (
        .clk(clk), .reset_n(reset_n), .din(qi), .dout(w_fi)
    );

    assign w_phase = {w_fa, w_fb};

    always_comb begin
        w_step_up = (w_phase != r_prev) && (w_phase == next_up(r_prev));
        w_step_dn = (w_phase != r_prev) && (r_prev == next_up(w_phase));
        w_illegal = (w_phase != r_prev) && !w_step_up && !w_step_dn;
`ifdef QUAD_DECODER_X4_EN
        w_count   = w_step_up || w_step_dn;
`else
        // x1: one count per full cycle, on the edge back into / out of phase 00.
        w_count   = (w_step_up && (w_phase == PH_00)) || (w_step_dn && (w_phase == PH_01));
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev    <= PH_00;
            r_fi_prev <= 1'b0;
            r_en      <= 1'b0;
            r_up      <= DIR_UP;
            r_load    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_prev    <= w_phase;
            r_fi_prev <= w_fi;
            r_en      <= w_count;
            if (w_count) begin
                r_up <= w_step_up ? DIR_UP : DIR_DN;
            end
            r_load    <= idx_arm && w_fi && !r_fi_prev;
            // A new illegal transition outranks a simultaneous clear.
            if (w_illegal) begin
                r_err <= 1'b1;
            end else if (clr_err) begin
                r_err <= 1'b0;
            end
        end
    end

    assign en   = r_en;
    assign up   = r_up;
    assign load = r_load;
    assign err  = r_err;
    assign d    = INDEX_VAL;

endmodule

// File: tb/tb_quad_decoder_298a.sv
// Randomised scoreboard bench for quad_decoder_298a: stimulus pushes expected
// en/load events, a negedge monitor pops and compares them as the DUT emits them.
module tb_quad_decoder_298a;

    localparam logic [7:0] IDX = 8'hA5;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       qa;
    logic       qb;
    logic       qi;
    logic       idx_arm;
    logic       clr_err;
    logic       en;
    logic       up;
    logic       load;
    logic [7:0] d;
    logic       err;

    quad_decoder_298a #(.FILT_CYCLES(3), .INDEX_VAL(IDX), .FILT_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .qa(qa), .qb(qb), .qi(qi),
        .idx_arm(idx_arm), .clr_err(clr_err),
        .en(en), .up(up), .load(load), .d(d), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   cyc;
        logic en;
        logic up;
        logic load;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every en/load pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && (en === 1'b1 || load === 1'b1)) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", 64'({en, load}), 64'(0));
            end else begin
                mon_e = sb.pop_front();
                chk("out_cycle", 64'(cyc), 64'(mon_e.cyc));
                chk("out_flags", 64'({en, up, load, d}), 64'({mon_e.en, mon_e.up, mon_e.load, IDX}));
            end
        end
    end

    initial begin
        logic [1:0] ring [4];
        logic [1:0] ph;
        int   pos, npos, delta, r, len, clr_mode, gpin, gstart, glen, k;
        logic cur_i, new_i, arm, glitch, m_up, m_err, step_en, ld;

        ring  = '{2'b00, 2'b10, 2'b11, 2'b01};
        pos   = 0;
        cur_i = 1'b0;
        m_up  = 1'b1;
        m_err = 1'b0;

        reset_n = 1'b0;
        qa = 1'b0; qb = 1'b0; qi = 1'b0; idx_arm = 1'b0; clr_err = 1'b0;

        // Reset held with random pins: outputs pinned at reset values.
        for (int j = 0; j < 5; j++) begin
            tick();
            qa      = 1'($urandom_range(0, 1));
            qb      = 1'($urandom_range(0, 1));
            qi      = 1'($urandom_range(0, 1));
            idx_arm = 1'($urandom_range(0, 1));
            clr_err = 1'($urandom_range(0, 1));
            #3;
            chk("rst_en",   64'(en),   64'(0));
            chk("rst_load", 64'(load), 64'(0));
            chk("rst_err",  64'(err),  64'(0));
            chk("rst_up",   64'(up),   64'(1));
            chk("rst_d",    64'(d),    64'(IDX));
        end
        tick();
        qa = 1'b0; qb = 1'b0; qi = 1'b0; idx_arm = 1'b0; clr_err = 1'b0;
        tick();
        reset_n = 1'b1;
        repeat (20) tick();
        chk("err_idle", 64'(err), 64'(0));
        chk("up_idle",  64'(up),  64'(1));

        // Random transactions: each new pin state is held 9..16 clocks.
        for (int t = 0; t < 250; t++) begin
            tick();
            k        = cyc;
            r        = $urandom_range(0, 99);
            delta    = (r < 45) ? 1 : (r < 75) ? 3 : (r < 88) ? 0 : 2;
            npos     = (pos + delta) % 4;
            ph       = ring[npos];
            new_i    = ($urandom_range(0, 99) < 30) ? !cur_i : cur_i;
            arm      = 1'($urandom_range(0, 1));
            len      = $urandom_range(9, 16);
            r        = $urandom_range(0, 99);
            clr_mode = (r < 15) ? 1 : (r < 30) ? 2 : 0;
            glitch   = ($urandom_range(0, 3) == 0);
            gpin     = $urandom_range(0, 2);
            gstart   = 4 + $urandom_range(0, 1);
            glen     = 1 + $urandom_range(0, 1);

`ifdef QUAD_DECODER_X4_EN
            step_en = (delta == 1) || (delta == 3);
`else
            step_en = (delta == 1 && ph == 2'b00) || (delta == 3 && ph == 2'b01);
`endif
            if (step_en) m_up = (delta == 1);
            ld = arm && new_i && !cur_i;
            if (step_en || ld) sb.push_back('{k + 6, step_en, m_up, ld});

            case (clr_mode)
                1:       m_err = (delta == 2);
                2:       m_err = 1'b0;
                default: m_err = m_err || (delta == 2);
            endcase

            qa = ph[1]; qb = ph[0]; qi = new_i; idx_arm = arm; clr_err = 1'b0;
            pos   = npos;
            cur_i = new_i;

            for (int j = 1; j < len; j++) begin
                tick();
                clr_err = (clr_mode == 1 && j == 5) || (clr_mode == 2 && j == 7);
                if (glitch && j == gstart) begin
                    case (gpin)
                        0:       qa = !qa;
                        1:       qb = !qb;
                        default: qi = !qi;
                    endcase
                end
                if (glitch && j == gstart + glen) begin
                    qa = ph[1]; qb = ph[0]; qi = new_i;
                end
            end
            clr_err = 1'b0;
            chk("err_level", 64'(err), 64'(m_err));
        end

        repeat (10) tick();
        chk("sb_empty", 64'(sb.size()), 64'(0));

        // Reset mid-operation: a pending change is discarded, and phase 11
        // after reset is flagged as an illegal jump from 00.
        tick();
        qa = 1'b1; qb = 1'b1; qi = 1'b0; idx_arm = 1'b0; clr_err = 1'b0;
        repeat (3) tick();
        #1;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_en",   64'(en),   64'(0));
        chk("mid_rst_load", 64'(load), 64'(0));
        chk("mid_rst_err",  64'(err),  64'(0));
        chk("mid_rst_up",   64'(up),   64'(1));
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (12) tick();
        chk("post_rst_err", 64'(err), 64'(1));
        chk("post_rst_up",  64'(up),  64'(1));
        chk("post_rst_sb",  64'(sb.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
